// File: rtl/cu_sched.sv
// Round-robin scheduler sharing one CU (ALU + multiplier) between NREQ requesters.
// One op in flight: IDLE accepts, EXEC holds operands for the op latency, RESP returns the tagged result.

package cu_sched_pkg;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_MUL
   } operation_t;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } flags_t;

endpackage

module cu_sched
   import cu_sched_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int MUL_CYCLES = 2,
   parameter int ISOLATE    = 1,
   localparam int IDW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ-1:0][15:0]       req_op1,
   input  logic [NREQ-1:0][15:0]       req_op2,
   input  operation_t [NREQ-1:0]       req_op,
   output logic [NREQ-1:0]             req_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [IDW-1:0]              rsp_id,
   output logic [15:0]                 rsp_result,
   output flags_t                      rsp_flags,
   output logic                        busy,
   output logic [15:0]                 cu_op1,
   output logic [15:0]                 cu_op2,
   output operation_t                  cu_op,
   input  logic [15:0]                 cu_result,
   input  flags_t                      cu_fls
);

   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IDW-1:0]   rr_ptr;
   logic [CW-1:0]    cnt;
   logic [15:0]      op1_q;
   logic [15:0]      op2_q;
   operation_t       op_q;
   logic [IDW-1:0]   id_q;
   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic             accept;

   // Winner search starts at rr_ptr and wraps, so the most recent winner is served last.
   always_comb begin
      int unsigned idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(idx);
         end
      end
   end

   assign accept = (state_q == IDLE) && grant_found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    if (cnt == '0) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         cnt        <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         op_q       <= OP_ADD;
         id_q       <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         if (accept) begin
            op1_q  <= req_op1[grant_idx];
            op2_q  <= req_op2[grant_idx];
            op_q   <= req_op[grant_idx];
            id_q   <= grant_idx;
            cnt    <= (req_op[grant_idx] == OP_MUL) ? CW'(MUL_CYCLES - 1) : '0;
            rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (state_q == EXEC) begin
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               rsp_result <= cu_result;
               rsp_flags  <= cu_fls;
               rsp_id     <= id_q;
            end
         end
      end
   end

   // Operands reach the CU only during EXEC when isolation is enabled; the opcode always holds.
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
      cu_op     = op_q;
      if ((ISOLATE != 0) && (state_q != EXEC)) begin
         cu_op1 = '0;
         cu_op2 = '0;
      end else begin
         cu_op1 = op1_q;
         cu_op2 = op2_q;
      end
   end

endmodule

// File: tb/tb_cu_sched.sv
// Scoreboard bench for cu_sched: a behavioural CU answers the DUT, and a monitor checks grants,
// operand isolation, EXEC length and tagged results against a queue-based reference model.

module tb_cu_sched;
   import cu_sched_pkg::*;

   localparam int NREQ       = 4;
   localparam int MUL_CYCLES = 2;
   localparam int IDW        = 2;

   typedef struct {
      int          id;
      logic [15:0] res;
      logic [3:0]  fl;
      int          exec_cycles;
   } exp_t;

   logic                   clk;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0][15:0]  req_op1;
   logic [NREQ-1:0][15:0]  req_op2;
   operation_t [NREQ-1:0]  req_op;
   logic [NREQ-1:0]        req_ready;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [15:0]            rsp_result;
   flags_t                 rsp_flags;
   logic                   busy;
   logic [15:0]            cu_op1;
   logic [15:0]            cu_op2;
   operation_t             cu_op;
   logic [15:0]            cu_result;
   flags_t                 cu_fls;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   int   model_ptr = 0;
   int   exec_len = 0;
   bit   in_resp = 0;
   logic [15:0] cur_op1, cur_op2;
   operation_t  cur_op;
   logic [21:0] held;

   cu_sched #(.NREQ(NREQ), .MUL_CYCLES(MUL_CYCLES), .ISOLATE(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2), .req_op(req_op),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
      .cu_op1(cu_op1), .cu_op2(cu_op2), .cu_op(cu_op),
      .cu_result(cu_result), .cu_fls(cu_fls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference CU behaviour: returns {flags, result}.
   function automatic logic [19:0] alu(logic [15:0] a, logic [15:0] b, operation_t op);
      logic [16:0] w;
      logic [31:0] p;
      logic [15:0] r;
      flags_t      f;
      f = '0;
      w = '0;
      p = '0;
      case (op)
         OP_ADD: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[15:0];
            f.carry = w[16];
            f.ovf = (a[15] == b[15]) && (r[15] != a[15]);
         end
         OP_SUB: begin
            w = {1'b0, a} - {1'b0, b};
            r = w[15:0];
            f.carry = w[16];
            f.ovf = (a[15] != b[15]) && (r[15] != a[15]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_MUL: begin
            p = a * b;
            r = p[15:0];
            f.carry = |p[31:16];
         end
         default: r = '0;
      endcase
      f.zero = (r == 16'h0);
      f.neg  = r[15];
      return {f, r};
   endfunction

   assign {cu_fls, cu_result} = alu(cu_op1, cu_op2, cu_op);

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: reference grant model, operand isolation, EXEC length and scoreboard pops.
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_ready;
      int win;
      int j;
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         model_ptr = 0;
         exec_len  = 0;
         in_resp   = 0;
      end else begin
         check_output("busy", 32'(busy), 32'(sb.size() != 0));
         exp_ready = '0;
         win = -1;
         if (!busy) begin
            for (int i = 0; i < NREQ; i++) begin
               j = (model_ptr + i) % NREQ;
               if (win < 0 && req_valid[j]) win = j;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         check_output("req_ready", 32'(req_ready), 32'(exp_ready));
         if (busy && !rsp_valid) begin
            exec_len++;
            check_output("exec_op1", 32'(cu_op1), 32'(cur_op1));
            check_output("exec_op2", 32'(cu_op2), 32'(cur_op2));
            check_output("exec_op", 32'(cu_op), 32'(cur_op));
         end else begin
            check_output("iso_op1", 32'(cu_op1), 32'h0);
            check_output("iso_op2", 32'(cu_op2), 32'h0);
         end
         if (win >= 0) begin
            e.id  = win;
            {e.fl, e.res} = alu(req_op1[win], req_op2[win], req_op[win]);
            e.exec_cycles = (req_op[win] == OP_MUL) ? MUL_CYCLES : 1;
            sb.push_back(e);
            cur_op1 = req_op1[win];
            cur_op2 = req_op2[win];
            cur_op  = req_op[win];
            model_ptr = (win + 1) % NREQ;
         end
         if (rsp_valid) begin
            if (!in_resp) begin
               in_resp = 1;
               held = {rsp_id, rsp_result, rsp_flags};
               if (sb.size() == 0) check_output("rsp_unexpected", 32'h1, 32'h0);
               else check_output("exec_len", 32'(exec_len), 32'(sb[0].exec_cycles));
            end else begin
               check_output("rsp_stable", 32'({rsp_id, rsp_result, rsp_flags}), 32'(held));
            end
            if (rsp_ready && sb.size() != 0) begin
               e = sb.pop_front();
               check_output("rsp_id", 32'(rsp_id), 32'(e.id));
               check_output("rsp_result", 32'(rsp_result), 32'(e.res));
               check_output("rsp_flags", 32'(rsp_flags), 32'(e.fl));
               in_resp  = 0;
               exec_len = 0;
            end
         end
      end
   end

   task automatic apply_stimulus(logic [NREQ-1:0] valid, bit ready);
      @(posedge clk);
      #1;
      req_valid = valid;
      rsp_ready = ready;
   endtask

   task automatic issue(int id, operation_t op, logic [15:0] a, logic [15:0] b);
      bit got;
      got = 0;
      @(posedge clk);
      #1;
      req_op[id]    = op;
      req_op1[id]   = a;
      req_op2[id]   = b;
      req_valid[id] = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = req_ready[id];
      end
      if (!got) check_output("grant_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(output logic [15:0] res, output logic [IDW-1:0] id);
      bit got;
      got = 0;
      res = '0;
      id  = '0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            got = 1;
            res = rsp_result;
            id  = rsp_id;
         end
      end
      if (!got) check_output("rsp_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0]    res;
      logic [IDW-1:0] id;
      bit             got;
      rst_n     = 1'b0;
      req_valid = '0;
      req_op1   = '0;
      req_op2   = '0;
      req_op    = {NREQ{OP_ADD}};
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_output("rst_busy", 32'(busy), 32'h0);
      check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      issue(0, OP_MUL, 16'd300, 16'd3);
      wait_rsp(res, id);
      check_output("mul_result", 32'(res), 32'd900);
      check_output("mul_id", 32'(id), 32'd0);

      issue(2, OP_ADD, 16'd5, 16'd7);
      wait_rsp(res, id);
      check_output("add_result", 32'(res), 32'd12);
      check_output("add_id", 32'(id), 32'd2);

      // Asynchronous reset in the middle of a MUL: outputs clear at once, no response follows.
      issue(1, OP_MUL, 16'd1234, 16'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("arst_busy", 32'(busy), 32'h0);
      check_output("arst_rsp_valid", 32'(rsp_valid), 32'h0);
      check_output("arst_req_ready", 32'(req_ready), 32'h0);
      check_output("arst_cu_op1", 32'(cu_op1), 32'h0);
      check_output("arst_cu_op2", 32'(cu_op2), 32'h0);
      check_output("arst_cu_op", 32'(cu_op), 32'(OP_ADD));
      check_output("arst_rsp_result", 32'(rsp_result), 32'h0);
      check_output("arst_rsp_id", 32'(rsp_id), 32'h0);
      check_output("arst_rsp_flags", 32'(rsp_flags), 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_output("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
      end

      // All requesters continuously valid: grants rotate 0,1,2,3,0.
      req_op = {NREQ{OP_ADD}};
      apply_stimulus('1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (req_ready != '0);
         end
         check_output("rr_order", 32'(req_ready), 32'(1 << (k % NREQ)));
         @(posedge clk);
      end

      // Backpressure on the op just granted.
      #1;
      rsp_ready = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      check_output("bp_reach_resp", 32'(got), 32'h1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_output("bp_hold_valid", 32'(rsp_valid), 32'h1);
      end
      apply_stimulus('0, 1'b1);
      @(negedge clk);
      check_output("bp_handshake", 32'(rsp_valid), 32'h1);
      @(negedge clk);
      check_output("bp_released", 32'(rsp_valid), 32'h0);
      check_output("bp_idle", 32'(busy), 32'h0);

      // Idle with toggling request data: operands stay isolated.
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            req_op1[i] = 16'($urandom);
            req_op2[i] = 16'($urandom);
         end
      end

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 800; c++) begin
         @(posedge clk);
         #1;
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            req_op1[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            req_op2[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            req_op[i]  = operation_t'($urandom_range(0, 5));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end

      apply_stimulus('0, 1'b1);
      repeat (10) @(negedge clk);
      check_output("drain_empty", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
